mem_stage_pipe: RTL and testbench

Parametrised memory-access pipeline stage for the 16-bit processor family and its wider derivatives. It holds word-organised data memory with word and byte accesses and resolves BEQ/BNE branches into a registered pc_src. It also registers the MEM/WB pipeline latch, with stall and flush handshakes. It sits between the EX stage (ALU result, Zero flag, control) and the WB stage.

---
 rtl/mem_stage_pipe.sv | 127 ++++++++++++
 tb/tb_mem_stage_pipe.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_pipe.sv
// MEM stage: word-organised data memory with word/byte access, BEQ/BNE resolution
// and the MEM/WB latch with stall/flush handling.
module mem_stage_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH_LOG2 = 8,
    parameter int REG_W      = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  byte_mode,
    input  logic                  sign_ext,
    input  logic                  branch,
    input  logic                  branch_ne,
    input  logic                  zero,
    input  logic                  reg_write_in,
    input  logic                  mem_to_reg_in,
    input  logic [REG_W-1:0]      rd_in,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic [ADDR_WIDTH-1:0] alu_result_out,
    output logic [REG_W-1:0]      rd_out,
    output logic                  reg_write_out,
    output logic                  mem_to_reg_out,
    output logic                  pc_src,
    output logic                  misaligned
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(LANES);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    function automatic logic [DATA_WIDTH-1:0] extend_byte(input logic signed [7:0] b,
                                                          input logic sx);
        logic signed [DATA_WIDTH-1:0] s;
        s = b;
        return sx ? s : {{(DATA_WIDTH-8){1'b0}}, b};
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DEPTH_LOG2-1:0] idx_p0;
    logic [OFF-1:0]        lane_p0;
    logic                  accept_p0;
    logic                  mis_p0;
    logic                  wr_en_p0;
    logic                  ld_en_p0;
    logic                  take_p0;
    logic [DATA_WIDTH-1:0] word_p0;
    logic [7:0]            byte_p0;
    logic [DATA_WIDTH-1:0] load_p0;

    // p0: decode and combinational memory read
    assign idx_p0    = address[DEPTH_LOG2+OFF-1:OFF];
    assign lane_p0   = address[OFF-1:0];
    assign accept_p0 = in_valid & ~stall & ~flush & ~reset;
    assign mis_p0    = (mem_read | mem_write) & ~byte_mode & (lane_p0 != '0);
    assign wr_en_p0  = accept_p0 & mem_write & ~mis_p0;
    assign ld_en_p0  = mem_read & ~mem_write & ~mis_p0;
    assign take_p0   = branch & (zero ^ branch_ne);
    assign word_p0   = mem[idx_p0];
    assign byte_p0   = word_p0[{lane_p0, 3'b000} +: 8];
    assign load_p0   = ld_en_p0 ? (byte_mode ? extend_byte(byte_p0, sign_ext) : word_p0)
                                : '0;

    always_ff @(posedge clock) begin
        if (wr_en_p0) begin
            if (byte_mode)
                mem[idx_p0][{lane_p0, 3'b000} +: 8] <= write_data[7:0];
            else
                mem[idx_p0] <= write_data;
        end
    end

    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] read_data_p1;
    logic [ADDR_WIDTH-1:0] alu_p1;
    logic [REG_W-1:0]      rd_p1;
    logic                  rw_p1;
    logic                  m2r_p1;
    logic                  pc_src_p1;
    logic                  mis_p1;

    // p1: MEM/WB latch; a stall with no flush leaves everything as it was
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1       <= 1'b0;
            read_data_p1 <= '0;
            alu_p1       <= '0;
            rd_p1        <= '0;
            rw_p1        <= 1'b0;
            m2r_p1       <= 1'b0;
            pc_src_p1    <= 1'b0;
            mis_p1       <= 1'b0;
        end else if (accept_p0) begin
            vld_p1       <= 1'b1;
            read_data_p1 <= load_p0;
            alu_p1       <= address;
            rd_p1        <= rd_in;
            rw_p1        <= reg_write_in & ~mis_p0;
            m2r_p1       <= mem_to_reg_in;
            pc_src_p1    <= take_p0;
            mis_p1       <= mis_p0;
        end else if (flush || !stall) begin
            vld_p1    <= 1'b0;
            rw_p1     <= 1'b0;
            pc_src_p1 <= 1'b0;
        end
    end

    assign out_valid      = vld_p1;
    assign read_data      = read_data_p1;
    assign alu_result_out = alu_p1;
    assign rd_out         = rd_p1;
    assign reg_write_out  = rw_p1;
    assign mem_to_reg_out = m2r_p1;
    assign pc_src         = pc_src_p1;
    assign misaligned     = mis_p1;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Bench for mem_stage_pipe: directed scenarios plus randomized traffic against a
// word-array reference model; a 32-bit instance covers the wide configuration.
module tb_mem_stage_pipe;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, in_valid, stall, flush, mem_read, mem_write, byte_mode, sign_ext;
    logic        branch, branch_ne, zero, reg_write_in, mem_to_reg_in;
    logic [2:0]  rd_in;
    logic [15:0] address, write_data;
    logic [31:0] w_write_data;

    logic        out_valid, reg_write_out, mem_to_reg_out, pc_src, misaligned;
    logic [15:0] read_data, alu_result_out;
    logic [2:0]  rd_out;

    logic        w_out_valid, w_reg_write_out, w_mem_to_reg_out, w_pc_src, w_misaligned;
    logic [31:0] w_read_data;
    logic [15:0] w_alu_result_out;
    logic [2:0]  w_rd_out;

    mem_stage_pipe dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .mem_read(mem_read), .mem_write(mem_write), .byte_mode(byte_mode),
        .sign_ext(sign_ext), .branch(branch), .branch_ne(branch_ne), .zero(zero),
        .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in), .rd_in(rd_in),
        .address(address), .write_data(write_data), .out_valid(out_valid),
        .read_data(read_data), .alu_result_out(alu_result_out), .rd_out(rd_out),
        .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
        .pc_src(pc_src), .misaligned(misaligned)
    );

    mem_stage_pipe #(.DATA_WIDTH(32)) dut_w (
        .clock(clock), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .mem_read(mem_read), .mem_write(mem_write), .byte_mode(byte_mode),
        .sign_ext(sign_ext), .branch(branch), .branch_ne(branch_ne), .zero(zero),
        .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in), .rd_in(rd_in),
        .address(address), .write_data(w_write_data), .out_valid(w_out_valid),
        .read_data(w_read_data), .alu_result_out(w_alu_result_out), .rd_out(w_rd_out),
        .reg_write_out(w_reg_write_out), .mem_to_reg_out(w_mem_to_reg_out),
        .pc_src(w_pc_src), .misaligned(w_misaligned)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model of the 16-bit instance: 256 words, two byte lanes each.
    int unsigned mmem [256];
    bit          mknown [256];
    bit          e_vld, e_rw, e_m2r, e_pc, e_mis, e_rd_known;
    int unsigned e_rdata, e_alu, e_rd;

    task automatic model_edge();
        int unsigned idx, lane, w, b, ld;
        bit mis, kn;
        if (reset) begin
            e_vld = 0; e_rw = 0; e_m2r = 0; e_pc = 0; e_mis = 0;
            e_rdata = 0; e_alu = 0; e_rd = 0; e_rd_known = 1;
        end else if (in_valid && !stall && !flush) begin
            idx  = (int'(address) / 2) % 256;
            lane = int'(address) % 2;
            mis  = (mem_read || mem_write) && !byte_mode && lane != 0;
            ld   = 0;
            kn   = 1;
            if (mem_read && !mem_write && !mis) begin
                w  = mmem[idx];
                kn = mknown[idx];
                if (byte_mode) begin
                    b  = (w / (1 << (8 * lane))) % 256;
                    ld = (sign_ext && b >= 128) ? b + 32'hFF00 : b;
                end else begin
                    ld = w;
                end
            end
            if (mem_write && !mis) begin
                if (byte_mode) begin
                    mmem[idx] = (mmem[idx] & ~(32'hFF << (8 * lane)))
                              | ((int'(write_data) % 256) << (8 * lane));
                end else begin
                    mmem[idx]   = int'(write_data);
                    mknown[idx] = 1;
                end
            end
            e_vld = 1; e_rdata = ld; e_rd_known = kn; e_alu = int'(address);
            e_rd = int'(rd_in); e_rw = reg_write_in && !mis; e_m2r = mem_to_reg_in;
            e_pc = branch && (zero != branch_ne); e_mis = mis;
        end else if (flush || !stall) begin
            e_vld = 0; e_rw = 0; e_pc = 0;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        reset = 0; in_valid = 0; stall = 0; flush = 0; mem_read = 0; mem_write = 0;
        byte_mode = 0; sign_ext = 0; branch = 0; branch_ne = 0; zero = 0;
        reg_write_in = 0; mem_to_reg_in = 0; rd_in = 0; address = 0; write_data = 0;
        w_write_data = 0;
    endtask

    task automatic op_store(input logic [15:0] a, input logic [15:0] d, input logic bm);
        clear_inputs();
        in_valid = 1; mem_write = 1; byte_mode = bm; address = a; write_data = d;
        w_write_data = {16'h0, d};
    endtask

    task automatic op_load(input logic [15:0] a, input logic bm, input logic sx);
        clear_inputs();
        in_valid = 1; mem_read = 1; byte_mode = bm; sign_ext = sx; address = a;
        reg_write_in = 1; mem_to_reg_in = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        tick();
        tick();
        n_cmp += 8;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid got %b want 0", out_valid); end
        if (read_data !== 16'h0) begin n_fail++; $display("FAIL reset read_data got %h want 0", read_data); end
        if (alu_result_out !== 16'h0) begin n_fail++; $display("FAIL reset alu_result_out got %h want 0", alu_result_out); end
        if (rd_out !== 3'h0) begin n_fail++; $display("FAIL reset rd_out got %h want 0", rd_out); end
        if (reg_write_out !== 1'b0) begin n_fail++; $display("FAIL reset reg_write_out got %b want 0", reg_write_out); end
        if (mem_to_reg_out !== 1'b0) begin n_fail++; $display("FAIL reset mem_to_reg_out got %b want 0", mem_to_reg_out); end
        if (pc_src !== 1'b0) begin n_fail++; $display("FAIL reset pc_src got %b want 0", pc_src); end
        if (misaligned !== 1'b0) begin n_fail++; $display("FAIL reset misaligned got %b want 0", misaligned); end
        reset = 0;
    endtask

    task automatic test_word_store_load();
        op_store(16'h0010, 16'hBEEF, 0);
        tick();
        op_load(16'h0010, 0, 0);
        tick();
        n_cmp += 2;
        if (read_data !== 16'hBEEF) begin n_fail++; $display("FAIL word_load read_data got %h want beef", read_data); end
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL word_load out_valid got %b want 1", out_valid); end
    endtask

    task automatic test_byte_access();
        op_store(16'h0010, 16'h1234, 0);
        tick();
        op_store(16'h0011, 16'h5580, 1);
        tick();
        op_load(16'h0010, 0, 0);
        tick();
        n_cmp++;
        if (read_data !== 16'h8034) begin n_fail++; $display("FAIL byte_store word got %h want 8034", read_data); end
        op_load(16'h0011, 1, 1);
        tick();
        n_cmp++;
        if (read_data !== 16'hFF80) begin n_fail++; $display("FAIL byte_load_sext got %h want ff80", read_data); end
        op_load(16'h0011, 1, 0);
        tick();
        n_cmp++;
        if (read_data !== 16'h0080) begin n_fail++; $display("FAIL byte_load_zext got %h want 0080", read_data); end
        op_load(16'h0010, 1, 1);
        tick();
        n_cmp++;
        if (read_data !== 16'h0034) begin n_fail++; $display("FAIL byte_load_lane0 got %h want 0034", read_data); end
    endtask

    task automatic test_misaligned();
        op_store(16'h0012, 16'h5555, 0);
        tick();
        op_store(16'h0013, 16'hAAAA, 0);
        reg_write_in = 1;
        tick();
        n_cmp += 3;
        if (misaligned !== 1'b1) begin n_fail++; $display("FAIL misaligned flag got %b want 1", misaligned); end
        if (reg_write_out !== 1'b0) begin n_fail++; $display("FAIL misaligned reg_write_out got %b want 0", reg_write_out); end
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL misaligned out_valid got %b want 1", out_valid); end
        op_load(16'h0013, 0, 0);
        tick();
        n_cmp++;
        if (read_data !== 16'h0000) begin n_fail++; $display("FAIL misaligned load got %h want 0000", read_data); end
        op_load(16'h0012, 0, 0);
        tick();
        n_cmp += 2;
        if (read_data !== 16'h5555) begin n_fail++; $display("FAIL misaligned word9 got %h want 5555", read_data); end
        if (misaligned !== 1'b0) begin n_fail++; $display("FAIL aligned misaligned got %b want 0", misaligned); end
    endtask

    task automatic test_branch();
        clear_inputs();
        in_valid = 1; branch = 1; zero = 1; branch_ne = 0;
        tick();
        n_cmp++;
        if (pc_src !== 1'b1) begin n_fail++; $display("FAIL beq_taken pc_src got %b want 1", pc_src); end
        clear_inputs();
        tick();
        n_cmp++;
        if (pc_src !== 1'b0) begin n_fail++; $display("FAIL beq_pulse pc_src got %b want 0", pc_src); end
        in_valid = 1; branch = 1; zero = 1; branch_ne = 1;
        tick();
        n_cmp++;
        if (pc_src !== 1'b0) begin n_fail++; $display("FAIL bne_not_taken pc_src got %b want 0", pc_src); end
        zero = 0;
        tick();
        n_cmp++;
        if (pc_src !== 1'b1) begin n_fail++; $display("FAIL bne_taken pc_src got %b want 1", pc_src); end
        branch = 0;
        tick();
        n_cmp++;
        if (pc_src !== 1'b0) begin n_fail++; $display("FAIL no_branch pc_src got %b want 0", pc_src); end
    endtask

    task automatic test_stall_flush();
        op_store(16'h0040, 16'h1111, 0);
        tick();
        op_load(16'h0040, 0, 0);
        rd_in = 3'd5;
        tick();
        op_store(16'h0040, 16'h2222, 0);
        rd_in = 3'd2; reg_write_in = 1; stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp += 4;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall out_valid got %b want 1", out_valid); end
            if (read_data !== 16'h1111) begin n_fail++; $display("FAIL stall read_data got %h want 1111", read_data); end
            if (rd_out !== 3'd5) begin n_fail++; $display("FAIL stall rd_out got %0d want 5", rd_out); end
            if (mem_to_reg_out !== 1'b1) begin n_fail++; $display("FAIL stall mem_to_reg_out got %b want 1", mem_to_reg_out); end
        end
        stall = 0;
        tick();
        n_cmp += 3;
        if (rd_out !== 3'd2) begin n_fail++; $display("FAIL release rd_out got %0d want 2", rd_out); end
        if (read_data !== 16'h0000) begin n_fail++; $display("FAIL release read_data got %h want 0000", read_data); end
        if (reg_write_out !== 1'b1) begin n_fail++; $display("FAIL release reg_write_out got %b want 1", reg_write_out); end
        op_load(16'h0040, 0, 0);
        tick();
        n_cmp++;
        if (read_data !== 16'h2222) begin n_fail++; $display("FAIL post_stall load got %h want 2222", read_data); end
        op_store(16'h0040, 16'h3333, 0);
        reg_write_in = 1; flush = 1; stall = 1;
        tick();
        n_cmp += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush out_valid got %b want 0", out_valid); end
        if (reg_write_out !== 1'b0) begin n_fail++; $display("FAIL flush reg_write_out got %b want 0", reg_write_out); end
        op_load(16'h0040, 0, 0);
        tick();
        n_cmp++;
        if (read_data !== 16'h2222) begin n_fail++; $display("FAIL post_flush load got %h want 2222", read_data); end
    endtask

    task automatic test_reset_mid();
        op_store(16'h0040, 16'h4444, 0);
        reg_write_in = 1; rd_in = 3'd7; reset = 1;
        tick();
        n_cmp += 4;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid out_valid got %b want 0", out_valid); end
        if (alu_result_out !== 16'h0) begin n_fail++; $display("FAIL rst_mid alu_result_out got %h want 0", alu_result_out); end
        if (rd_out !== 3'd0) begin n_fail++; $display("FAIL rst_mid rd_out got %0d want 0", rd_out); end
        if (read_data !== 16'h0) begin n_fail++; $display("FAIL rst_mid read_data got %h want 0", read_data); end
        op_load(16'h0040, 0, 0);
        tick();
        n_cmp++;
        if (read_data !== 16'h2222) begin n_fail++; $display("FAIL rst_mid store_lost got %h want 2222", read_data); end
    endtask

    task automatic test_wide();
        op_store(16'h0004, 16'h0, 0);
        w_write_data = 32'h11223344;
        tick();
        op_store(16'h0006, 16'h0, 1);
        w_write_data = 32'h000000AB;
        tick();
        op_load(16'h0004, 0, 0);
        tick();
        n_cmp++;
        if (w_read_data !== 32'h11AB3344) begin n_fail++; $display("FAIL wide_byte_store got %h want 11ab3344", w_read_data); end
        op_load(16'h0006, 1, 1);
        tick();
        n_cmp++;
        if (w_read_data !== 32'hFFFFFFAB) begin n_fail++; $display("FAIL wide_byte_sext got %h want ffffffab", w_read_data); end
        op_load(16'h0006, 0, 0);
        tick();
        n_cmp += 3;
        if (w_misaligned !== 1'b1) begin n_fail++; $display("FAIL wide_misaligned got %b want 1", w_misaligned); end
        if (w_read_data !== 32'h0) begin n_fail++; $display("FAIL wide_mis_read got %h want 0", w_read_data); end
        if (w_reg_write_out !== 1'b0) begin n_fail++; $display("FAIL wide_mis_rw got %b want 0", w_reg_write_out); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            op_store(16'(i * 2), 16'($urandom), 0);
            tick();
        end
        for (int n = 0; n < 400; n++) begin
            reset         = ($urandom_range(0, 99) < 3);
            in_valid      = ($urandom_range(0, 99) < 80);
            stall         = ($urandom_range(0, 99) < 15);
            flush         = ($urandom_range(0, 99) < 10);
            mem_read      = 1'($urandom);
            mem_write     = ($urandom_range(0, 99) < 35);
            byte_mode     = 1'($urandom);
            sign_ext      = 1'($urandom);
            branch        = 1'($urandom);
            branch_ne     = 1'($urandom);
            zero          = 1'($urandom);
            reg_write_in  = 1'($urandom);
            mem_to_reg_in = 1'($urandom);
            rd_in         = 3'($urandom);
            address       = (16'($urandom) & 16'hFE00) | 16'($urandom_range(0, 31));
            write_data    = 16'($urandom);
            w_write_data  = {16'h0, write_data};
            tick();
            n_cmp += 7;
            if (out_valid !== e_vld) begin n_fail++; $display("FAIL rand out_valid cyc %0d got %b want %b", n, out_valid, e_vld); end
            if (alu_result_out !== 16'(e_alu)) begin n_fail++; $display("FAIL rand alu cyc %0d got %h want %h", n, alu_result_out, 16'(e_alu)); end
            if (rd_out !== 3'(e_rd)) begin n_fail++; $display("FAIL rand rd_out cyc %0d got %0d want %0d", n, rd_out, e_rd); end
            if (reg_write_out !== e_rw) begin n_fail++; $display("FAIL rand reg_write_out cyc %0d got %b want %b", n, reg_write_out, e_rw); end
            if (mem_to_reg_out !== e_m2r) begin n_fail++; $display("FAIL rand mem_to_reg_out cyc %0d got %b want %b", n, mem_to_reg_out, e_m2r); end
            if (pc_src !== e_pc) begin n_fail++; $display("FAIL rand pc_src cyc %0d got %b want %b", n, pc_src, e_pc); end
            if (misaligned !== e_mis) begin n_fail++; $display("FAIL rand misaligned cyc %0d got %b want %b", n, misaligned, e_mis); end
            if (e_rd_known) begin
                n_cmp++;
                if (read_data !== 16'(e_rdata)) begin n_fail++; $display("FAIL rand read_data cyc %0d got %h want %h", n, read_data, 16'(e_rdata)); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mmem[i]   = 0;
            mknown[i] = 0;
        end
        e_vld = 0; e_rw = 0; e_m2r = 0; e_pc = 0; e_mis = 0;
        e_rdata = 0; e_alu = 0; e_rd = 0; e_rd_known = 0;
        clear_inputs();
        test_reset();
        test_word_store_load();
        test_byte_access();
        test_misaligned();
        test_branch();
        test_stall_flush();
        test_reset_mid();
        test_wide();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
